// File: rtl/neuron_layer_ctrl_if.sv
// ---------------------------------------------------------------------------
// neuron_layer_ctrl_if
//   Bundle between the layer sequencer and the shared 4-input neuron.
//   master : sequencer side (drives data/weights/data_ready, takes n_out)
//   slave  : neuron side    (takes data/weights/data_ready, drives n_out)
//   n_data0..3   8-bit neuron data inputs
//   n_w0..3      8-bit neuron weight inputs
//   n_data_ready one-cycle "operands valid" strobe
//   n_out        8-bit neuron result
// ---------------------------------------------------------------------------
interface neuron_layer_ctrl_if;
  logic [7:0] n_data0, n_data1, n_data2, n_data3;
  logic [7:0] n_w0, n_w1, n_w2, n_w3;
  logic       n_data_ready;
  logic [7:0] n_out;

  modport master (
    output n_data0, n_data1, n_data2, n_data3,
    output n_w0, n_w1, n_w2, n_w3,
    output n_data_ready,
    input  n_out
  );

  modport slave (
    input  n_data0, n_data1, n_data2, n_data3,
    input  n_w0, n_w1, n_w2, n_w3,
    input  n_data_ready,
    output n_out
  );
endinterface

// File: rtl/neuron_layer_ctrl.sv
// ---------------------------------------------------------------------------
// neuron_layer_ctrl
//   Time-multiplexes one shared 4-input neuron across NUM_OUT logical output
//   neurons. A start latches the input vector, then each output index gets
//   one ISSUE cycle (operands + data_ready) and PIPE_LAT WAIT cycles, after
//   which the neuron output is stored in the result file.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_we/addr/wdata       weight write {out idx, in idx}; cfg_err pulses
//                           for one cycle when a write is rejected
//   start, abort            begin / cancel a layer evaluation
//   in_data0..3             input vector, latched on an accepted start
//   busy, done, res_valid   status: running, finished pulse, file complete
//   rd_addr / rd_data       combinational result read (0 when out of range)
//   nrn                     neuron bundle (master side)
// ---------------------------------------------------------------------------
module neuron_layer_ctrl #(
  parameter int NUM_OUT  = 4,
  parameter int PIPE_LAT = 3,
  parameter int IDX_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [IDX_W+1:0]     cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic                 cfg_err,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           in_data0,
  input  logic [7:0]           in_data1,
  input  logic [7:0]           in_data2,
  input  logic [7:0]           in_data3,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [7:0]           rd_data,
  neuron_layer_ctrl_if.master  nrn
);

  localparam int               CNT_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(PIPE_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W:0]   NUM_OUT_X = (IDX_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             n_data_ready_q;
  logic [7:0]       n_data_q [4];   // doubles as the latched input vector
  logic [7:0]       n_w_q    [4];
  logic [7:0]       weight   [NUM_OUT][4];
  logic [7:0]       result   [NUM_OUT];

  // Weight-write decode: only an idle controller accepts writes, and only
  // for output indices that exist.
  logic [IDX_W-1:0] wr_oidx;
  logic [1:0]       wr_iidx;
  logic             wr_ok;

  assign wr_oidx = cfg_addr[IDX_W+1:2];
  assign wr_iidx = cfg_addr[1:0];
  assign wr_ok   = cfg_we && (state == S_IDLE) && ({1'b0, wr_oidx} < NUM_OUT_X);

  // NOTE: the weight file must come out of reset as all 8'h01, so it is built
  // from resettable flops rather than an inferred RAM (the result file too).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int o = 0; o < NUM_OUT; o++) begin
        for (int k = 0; k < 4; k++) begin
          weight[o][k] <= 8'h01;
        end
      end
    end else begin
      cfg_err <= cfg_we && !wr_ok;
      if (wr_ok) begin
        weight[wr_oidx][wr_iidx] <= cfg_wdata;
      end
    end
  end

  // Weight row for the next ISSUE. A write landing on the same edge as the
  // accepted start is forwarded so idx 0 already sees the new byte.
  logic [IDX_W-1:0] next_idx;
  logic [7:0]       issue_w [4];

  // NOTE: combinational logic uses blocking '='; registers use '<=' so every
  // flop samples pre-edge values regardless of statement order.
  always_comb begin
    // NOTE: defaults first so every path assigns each output; a missed path
    // would otherwise infer a latch.
    next_idx = '0;
    if (state == S_WAIT && idx != LAST_IDX) begin
      next_idx = idx + 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      issue_w[k] = weight[next_idx][k];
      if (wr_ok && wr_oidx == next_idx && wr_iidx == 2'(k)) begin
        issue_w[k] = cfg_wdata;
      end
    end
  end

  // Sequencer: every output is registered and changes only on state edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      res_valid      <= 1'b0;
      n_data_ready_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        n_data_q[k] <= 8'h00;
        n_w_q[k]    <= 8'h00;
      end
      for (int o = 0; o < NUM_OUT; o++) begin
        result[o] <= 8'h00;
      end
    end else begin
      done           <= 1'b0;
      n_data_ready_q <= 1'b0;
      if (busy && abort) begin
        // Abort wins over capture and over the normal transition.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              n_data_q[0]    <= in_data0;
              n_data_q[1]    <= in_data1;
              n_data_q[2]    <= in_data2;
              n_data_q[3]    <= in_data3;
              n_w_q          <= issue_w;
              n_data_ready_q <= 1'b1;
              idx            <= '0;
              res_valid      <= 1'b0;
              busy           <= 1'b1;
              state          <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wait_cnt <= CNT_LOAD;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              result[idx] <= nrn.n_out;
              if (idx == LAST_IDX) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                res_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                idx            <= next_idx;
                n_w_q          <= issue_w;
                n_data_ready_q <= 1'b1;
                state          <= S_ISSUE;
              end
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rd_data = ({1'b0, rd_addr} < NUM_OUT_X) ? result[rd_addr] : 8'h00;

  assign nrn.n_data0      = n_data_q[0];
  assign nrn.n_data1      = n_data_q[1];
  assign nrn.n_data2      = n_data_q[2];
  assign nrn.n_data3      = n_data_q[3];
  assign nrn.n_w0         = n_w_q[0];
  assign nrn.n_w1         = n_w_q[1];
  assign nrn.n_w2         = n_w_q[2];
  assign nrn.n_w3         = n_w_q[3];
  assign nrn.n_data_ready = n_data_ready_q;

endmodule
